// File: rtl/mlaccel_pkg.sv
// rtl/mlaccel_pkg.sv - shared SMEM widths, port ids and completion tag type
package mlaccel_pkg;

  localparam int SMEM_AW    = 16;
  localparam int SMEM_DW    = 32;
  localparam int SMEM_STRBW = SMEM_DW / 8;

  typedef enum logic {
    PORT_HOST = 1'b0,
    PORT_SEQ  = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

endpackage

// File: rtl/mlaccel_tag_pipe.sv
// rtl/mlaccel_tag_pipe.sv - fixed-depth shift pipe of {valid, port} completion tags
module mlaccel_tag_pipe
  import mlaccel_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  tag_t i_tag,
  output tag_t o_tag,
  output logic o_any_valid
);

  tag_t r_stage [DEPTH];
  logic w_any;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  always_comb begin
    w_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_any = w_any | r_stage[i].valid;
    end
  end

  assign o_tag       = r_stage[DEPTH-1];
  assign o_any_valid = w_any;

endmodule

// File: rtl/mlaccel_smem_arbiter.sv
// rtl/mlaccel_smem_arbiter.sv - round-robin SMEM arbiter between host loader and instruction fetch
module mlaccel_smem_arbiter
  import mlaccel_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_seq_enable,
  input  logic                  i_host_valid,
  input  logic                  i_host_write,
  input  logic [SMEM_AW-1:0]    i_host_addr,
  input  logic [SMEM_DW-1:0]    i_host_wdata,
  input  logic [SMEM_STRBW-1:0] i_host_wstrb,
  output logic                  o_host_ready,
  output logic [SMEM_DW-1:0]    o_host_rdata,
  input  logic                  i_seq_valid,
  input  logic [SMEM_AW-1:0]    i_seq_addr,
  output logic                  o_seq_ready,
  output logic [SMEM_DW-1:0]    o_seq_data,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [SMEM_AW-1:0]    o_mem_addr,
  output logic [SMEM_DW-1:0]    o_mem_wdata,
  output logic [SMEM_STRBW-1:0] o_mem_wstrb,
  input  logic [SMEM_DW-1:0]    i_mem_rdata,
  output logic                  o_busy
);

  logic                  r_host_out;
  logic                  r_seq_out;
  port_e                 r_last_grant;
  logic                  r_mem_en;
  logic                  r_mem_we;
  port_e                 r_mem_port;
  logic [SMEM_AW-1:0]    r_mem_addr;
  logic [SMEM_DW-1:0]    r_mem_wdata;
  logic [SMEM_STRBW-1:0] r_mem_wstrb;

  logic w_host_elig;
  logic w_seq_elig;
  logic w_grant_host;
  logic w_grant_seq;
  logic w_host_done;
  logic w_seq_done;
  logic w_pipe_busy;
  tag_t w_tag_in;
  tag_t w_tag_out;

  // A port is eligible only while it has nothing in flight; ties go to the port not served last.
  always_comb begin
    w_host_elig  = i_host_valid && !r_host_out;
    w_seq_elig   = i_seq_valid && i_seq_enable && !r_seq_out;
    w_grant_host = w_host_elig && (!w_seq_elig || (r_last_grant == PORT_SEQ));
    w_grant_seq  = w_seq_elig && !w_grant_host;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_port   <= PORT_SEQ;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
      r_last_grant <= PORT_SEQ;
    end else begin
      r_mem_en <= w_grant_host || w_grant_seq;
      if (w_grant_host) begin
        r_mem_we     <= i_host_write;
        r_mem_port   <= PORT_HOST;
        r_mem_addr   <= i_host_addr;
        r_mem_wdata  <= i_host_wdata;
        r_mem_wstrb  <= i_host_wstrb;
        r_last_grant <= PORT_HOST;
      end else if (w_grant_seq) begin
        r_mem_we     <= 1'b0;
        r_mem_port   <= PORT_SEQ;
        r_mem_addr   <= i_seq_addr;
        r_last_grant <= PORT_SEQ;
      end else begin
        r_mem_we <= 1'b0;
      end
    end
  end

  // Outstanding flags never set and clear in the same cycle: a port cannot be granted while in flight.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_host_out <= 1'b0;
      r_seq_out  <= 1'b0;
    end else begin
      r_host_out <= (r_host_out && !w_host_done) || w_grant_host;
      r_seq_out  <= (r_seq_out && !w_seq_done) || w_grant_seq;
    end
  end

  assign w_tag_in = '{valid: r_mem_en, port: r_mem_port};

  mlaccel_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_tag_pipe (
    .i_clk       (i_clock),
    .i_rst       (i_reset),
    .i_tag       (w_tag_in),
    .o_tag       (w_tag_out),
    .o_any_valid (w_pipe_busy)
  );

  assign w_host_done = w_tag_out.valid && (w_tag_out.port == PORT_HOST);
  assign w_seq_done  = w_tag_out.valid && (w_tag_out.port == PORT_SEQ);

  assign o_host_ready = w_host_done;
  assign o_seq_ready  = w_seq_done;
  assign o_host_rdata = i_mem_rdata;
  assign o_seq_data   = i_mem_rdata;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_wstrb  = r_mem_wstrb;
  assign o_busy       = w_pipe_busy || r_mem_en;

endmodule

// File: tb/tb_mlaccel_smem_arbiter.sv
// tb/tb_mlaccel_smem_arbiter.sv - directed bench with scheduled-event reference model for the SMEM arbiter
module tb_mlaccel_smem_arbiter;
  import mlaccel_pkg::*;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seq_enable = 1'b1;
  logic        host_valid = 1'b0;
  logic        host_write = 1'b0;
  logic [15:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic [3:0]  host_wstrb = '0;
  logic        host_ready;
  logic [31:0] host_rdata;
  logic        seq_valid = 1'b0;
  logic [15:0] seq_addr = '0;
  logic        seq_ready;
  logic [31:0] seq_data;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mlaccel_smem_arbiter #(.READ_LATENCY(L)) dut (
    .i_clock(clk), .i_reset(rst), .i_seq_enable(seq_enable),
    .i_host_valid(host_valid), .i_host_write(host_write), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata), .i_host_wstrb(host_wstrb),
    .o_host_ready(host_ready), .o_host_rdata(host_rdata),
    .i_seq_valid(seq_valid), .i_seq_addr(seq_addr),
    .o_seq_ready(seq_ready), .o_seq_data(seq_data),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // SRAM macro: registered read, L cycles from mem_en to data.
  logic [31:0] sram [1024];
  logic [31:0] rd_pipe [L];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) sram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? sram[mem_addr[9:0]] : 32'hBAD0_BAD0;
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[L-1];

  // Reference model: decides grants from the request rules and schedules the resulting events by cycle number.
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } acc_t;

  int          cyc = 0;
  int          host_busy_until = -1;
  int          seq_busy_until = -1;
  bit          last_was_host = 1'b0;
  logic [31:0] gold [1024];
  acc_t        exp_acc [int];
  logic [32:0] exp_host [int];
  logic [31:0] exp_seq [int];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_acc.delete();
      exp_host.delete();
      exp_seq.delete();
      host_busy_until = -1;
      seq_busy_until = -1;
      last_was_host = 1'b0;
      cyc = 0;
    end else begin : decide
      bit he, se;
      int a;
      he = host_valid && (cyc > host_busy_until);
      se = seq_valid && seq_enable && (cyc > seq_busy_until);
      if (he && (!se || !last_was_host)) begin
        a = int'(host_addr[9:0]);
        exp_acc[cyc+1] = '{we: host_write, addr: host_addr, wdata: host_wdata, wstrb: host_wstrb};
        if (host_write)
          for (int b = 0; b < 4; b++)
            if (host_wstrb[b]) gold[a][8*b +: 8] = host_wdata[8*b +: 8];
        exp_host[cyc+1+L] = {!host_write, gold[a]};
        host_busy_until = cyc + 1 + L;
        last_was_host = 1'b1;
      end else if (se) begin
        exp_acc[cyc+1] = '{we: 1'b0, addr: seq_addr, wdata: 32'h0, wstrb: 4'h0};
        exp_seq[cyc+1+L] = gold[int'(seq_addr[9:0])];
        seq_busy_until = cyc + 1 + L;
        last_was_host = 1'b0;
      end
      cyc++;
    end
  end

  // Per-cycle compare against the model, plus request-hold protocol checks.
  logic [15:0] addr_q [$];
  int          ready_cnt = 0;
  bit          hpend = 1'b0, spend = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
      chk("rst_host_ready", host_ready, 0);
      chk("rst_seq_ready", seq_ready, 0);
      chk("rst_busy", busy, 0);
      hpend = 1'b0;
      spend = 1'b0;
    end else begin : cmp
      bit bexp;
      chk("mem_en", mem_en, exp_acc.exists(cyc));
      if (exp_acc.exists(cyc)) begin
        chk("mem_we", mem_we, exp_acc[cyc].we);
        chk("mem_addr", mem_addr, exp_acc[cyc].addr);
        if (exp_acc[cyc].we) begin
          chk("mem_wdata", mem_wdata, exp_acc[cyc].wdata);
          chk("mem_wstrb", mem_wstrb, exp_acc[cyc].wstrb);
        end
      end
      chk("host_ready", host_ready, exp_host.exists(cyc));
      if (exp_host.exists(cyc) && exp_host[cyc][32]) chk("host_rdata", host_rdata, exp_host[cyc][31:0]);
      chk("seq_ready", seq_ready, exp_seq.exists(cyc));
      if (exp_seq.exists(cyc)) chk("seq_data", seq_data, exp_seq[cyc]);
      bexp = 1'b0;
      for (int k = 0; k <= L; k++) if (exp_acc.exists(cyc - k)) bexp = 1'b1;
      chk("busy", busy, bexp);
      if (hpend) chk("host_valid_held", host_valid, 1);
      if (spend) chk("seq_valid_held", seq_valid, 1);
      hpend = host_valid && !host_ready;
      spend = seq_valid && !seq_ready;
      if (mem_en) addr_q.push_back(mem_addr);
      if (host_ready || seq_ready) ready_cnt++;
    end
  end

  task automatic host_req(input bit wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int t_req, output int t_rdy, output logic [31:0] rd);
    host_valid = 1'b1; host_write = wr; host_addr = a; host_wdata = d; host_wstrb = s;
    t_req = cyc;
    t_rdy = -1;
    rd = 'x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (host_ready) begin t_rdy = cyc; rd = host_rdata; break; end
    end
    if (t_rdy < 0) chk("host_timeout", 0, 1);
    @(posedge clk); #1;
    host_valid = 1'b0;
  endtask

  task automatic seq_req(input logic [15:0] a, output int t_req, output int t_rdy, output logic [31:0] rd);
    seq_valid = 1'b1; seq_addr = a;
    t_req = cyc;
    t_rdy = -1;
    rd = 'x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (seq_ready) begin t_rdy = cyc; rd = seq_data; break; end
    end
    if (t_rdy < 0) chk("seq_timeout", 0, 1);
    @(posedge clk); #1;
    seq_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int          tq, tr, tq2, tr2, t_en, lat_h, lat_s;
  logic [31:0] rd, rd2;
  logic [31:0] prog [4];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 32'hA5A5_0000 | i;
      gold[i] = 32'hA5A5_0000 | i;
    end
    for (int i = 0; i < L; i++) rd_pipe[i] = '0;
    prog[0] = 32'h1111_0001; prog[1] = 32'h2222_0002; prog[2] = 32'h3333_0003; prog[3] = 32'h4444_0004;

    repeat (3) @(posedge clk);
    #1 chk("reset_busy", busy, 0);
    rst = 1'b0;

    // Host write then read back; both complete L+1 cycles after request (4 with L=3).
    host_req(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, tq, tr, rd);
    chk("t1_wr_latency", tr - tq, 4);
    host_req(1'b0, 16'h0010, 32'h0, 4'h0, tq, tr, rd);
    chk("t1_rd_latency", tr - tq, 4);
    chk("t1_rd_data", rd, 32'hDEADBEEF);

    // Simultaneous requests right after reset: host wins the tie, seq follows one cycle later.
    do_reset();
    addr_q.delete();
    fork
      host_req(1'b0, 16'h0001, 32'h0, 4'h0, tq, tr, rd);
      seq_req(16'h0002, tq2, tr2, rd2);
    join
    chk("t2_first_addr", addr_q[0], 16'h0001);
    chk("t2_second_addr", addr_q[1], 16'h0002);
    chk("t2_ready_gap", tr2 - tr, 1);
    chk("t2_host_data", rd, 32'hA5A5_0001);
    chk("t2_seq_data", rd2, 32'hA5A5_0002);

    // Host-exclusive mode: fetch stays pending until seq_enable rises.
    seq_enable = 1'b0;
    fork
      seq_req(16'h0003, tq2, tr2, rd2);
      begin
        host_req(1'b1, 16'h0020, 32'hCAFE_0020, 4'hF, tq, tr, rd);
        host_req(1'b1, 16'h0021, 32'h1234_5678, 4'b0101, tq, tr, rd);
        host_req(1'b1, 16'h0022, 32'hCAFE_0022, 4'hF, tq, tr, rd);
        repeat (8) @(posedge clk);
        #1 t_en = cyc;
        seq_enable = 1'b1;
      end
    join
    chk("t3_seq_after_enable", tr2 - t_en, 4);
    chk("t3_seq_data", rd2, 32'hA5A5_0003);
    host_req(1'b0, 16'h0021, 32'h0, 4'h0, tq, tr, rd);
    chk("t3_strobe_merge", rd, 32'hA534_0078);

    // Saturated traffic on both ports: nobody waits more than two grant slots.
    lat_h = 0;
    lat_s = 0;
    fork
      for (int i = 0; i < 8; i++) begin
        host_req(1'b0, 16'h0100 + 16'(i), 32'h0, 4'h0, tq, tr, rd);
        if (tr - tq > lat_h) lat_h = tr - tq;
      end
      for (int i = 0; i < 8; i++) begin
        seq_req(16'h0200 + 16'(i), tq2, tr2, rd2);
        if (tr2 - tq2 > lat_s) lat_s = tr2 - tq2;
        @(posedge clk); #1;
      end
    join
    chk("t4_host_max_wait", 32'(lat_h <= 6), 1);
    chk("t4_seq_max_wait", 32'(lat_s <= 6), 1);

    // Reset two cycles after the access issued: results discarded, nothing completes.
    @(posedge clk); #1;
    host_valid = 1'b1; host_write = 1'b0; host_addr = 16'h0005;
    @(posedge clk); #1;
    chk("t5_issued", mem_en, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    host_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_mem_en", mem_en, 0);
    chk("t5_host_ready", host_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_mem_addr", mem_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ready_cnt = 0;
    repeat (L + 3) @(posedge clk);
    #1;
    chk("t5_no_ready_after", ready_cnt, 0);
    chk("t5_busy_after", busy, 0);

    // Host loads a 4-word program, fetch port reads it back in order.
    for (int i = 0; i < 4; i++) host_req(1'b1, 16'h0040 + 16'(i), prog[i], 4'hF, tq, tr, rd);
    for (int i = 0; i < 4; i++) begin
      seq_req(16'h0040 + 16'(i), tq2, tr2, rd2);
      chk("t6_fetch_word", rd2, prog[i]);
      @(posedge clk); #1;
    end
    chk("t6_word0_literal", sram[64], 32'h1111_0001);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
